pll_reset_sequencer: RTL

Reset and lock supervisor for the system PLL (50 MHz reference in; 48/24/12 MHz domain clocks out). Runs on the free-running reference clock and drives the PLL reset pin. Qualifies the PLL `locked` flag and releases the per-domain reset requests in a fixed staggered order. On lock timeout, lock loss or a soft-reset request it re-asserts all domain resets and re-runs the PLL reset sequence.

---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/pll_lock_sync.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Purpose : shared types and helpers for the PLL reset/lock sequencer.
// Contents: sequencer state enum, retry counter width, shared-counter width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } seq_state_e;

    localparam int unsigned RETRY_W = 8;

    // Width of the single counter shared by all states: enough to hold the largest interval.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Purpose : two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
// Ports   : clk_i   - sampling clock
//           rst_i   - asynchronous active-high reset, clears both flops
//           d_i     - asynchronous input
//           q_o     - synchronized output (2 edges of latency)
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability stage followed by the stable stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Purpose : PLL reset and lock supervisor. Pulses the PLL reset, qualifies the lock flag,
//           then releases per-domain resets in ascending order with a fixed stagger.
//           Lock timeout, lock loss or soft reset re-asserts every domain reset.
// Ports   : refclk      - free-running reference clock (only clock)
//           rst         - asynchronous active-high block reset
//           locked      - PLL lock flag, asynchronous
//           soft_reset  - level reset request, synchronous to refclk
//           pll_rst     - PLL reset, active high
//           rst_out     - per-domain reset requests, active high, index 0 released first
//           ready       - all domains released with lock qualified
//           retry_count - lock-timeout retries, saturating
//           lock_fail   - sticky, set on first lock timeout
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 8
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   locked,
    input  logic                   soft_reset,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic [RETRY_W-1:0]     retry_count,
    output logic                   lock_fail
);

    localparam int unsigned CNT_W = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES,
                                              PLL_RST_CYCLES, STAGGER_CYCLES);
    localparam int unsigned DOM_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [DOM_W-1:0] DOM_LAST     = DOM_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_RST = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] DOM0    = NUM_DOMAINS'(1);

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DOM_W-1:0]       dom_q, dom_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   lock_fail_q, lock_fail_d;
    logic                   locked_s;
    logic [DOM_W-1:0]       dom_nxt;

    pll_lock_sync u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    assign dom_nxt = dom_q + DOM_W'(1);

    // State, counter and output registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RESET;
            cnt_q       <= '0;
            dom_q       <= '0;
            pll_rst_q   <= 1'b1;
            rst_out_q   <= ALL_RST;
            ready_q     <= 1'b0;
            retry_q     <= '0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dom_q       <= dom_d;
            pll_rst_q   <= pll_rst_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            retry_q     <= retry_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    // Next-state and next-output logic; soft reset > lock loss > timeout > advance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dom_d       = dom_q;
        rst_out_d   = rst_out_q;
        ready_d     = ready_q;
        retry_d     = retry_q;
        lock_fail_d = lock_fail_q;

        if (soft_reset) begin
            state_d   = PLL_RESET;
            cnt_d     = '0;
            rst_out_d = ALL_RST;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    rst_out_d = ALL_RST;
                    ready_d   = 1'b0;
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = PLL_RESET;
                        cnt_d       = '0;
                        retry_d     = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
                        lock_fail_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = RELEASE;
                        cnt_d     = '0;
                        dom_d     = '0;
                        rst_out_d = ALL_RST & ~DOM0;
                        if (NUM_DOMAINS == 1) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!locked_s) begin
                        state_d   = PLL_RESET;
                        cnt_d     = '0;
                        rst_out_d = ALL_RST;
                        ready_d   = 1'b0;
                    end else if (cnt_q == STAGGER_LAST) begin
                        cnt_d     = '0;
                        dom_d     = dom_nxt;
                        rst_out_d = rst_out_q & ~(DOM0 << dom_nxt);
                        if (dom_nxt == DOM_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d   = PLL_RESET;
                        cnt_d     = '0;
                        rst_out_d = ALL_RST;
                        ready_d   = 1'b0;
                    end
                end
                default: begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    rst_out_d = ALL_RST;
                    ready_d   = 1'b0;
                end
            endcase
        end

        pll_rst_d = (state_d == PLL_RESET);
    end

    assign pll_rst     = pll_rst_q;
    assign rst_out     = rst_out_q;
    assign ready       = ready_q;
    assign retry_count = retry_q;
    assign lock_fail   = lock_fail_q;

endmodule
